// File: rtl/key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// key_expansion_ctrl
//
// Sequencer for an AES-128 key-expansion datapath built from four 32-bit
// word registers W0..W3. After a start request it loads the cipher key
// (round key 0), then derives each following round key one word per cycle.
// For every word it drives the register enable, the RotWord/SubWord/Rcon
// select and the Rcon constant. Each finished round key is offered to the
// cipher core through a valid/ready handshake before the next one is built.
//
// Parameters
//   NUM_ROUNDS  number of round keys after round key 0 (round_idx 0..NUM_ROUNDS)
//   RCON_INIT   Rcon value used to compute round key 1
//
// Ports
//   Clk         in   1  clock, rising edge
//   Rst         in   1  synchronous reset, active-high
//   start       in   1  begin an expansion; only looked at while idle
//   rk_ready    in   1  consumer takes the round key currently offered
//   busy        out  1  high whenever the sequencer is not idle
//   key_load    out  1  select the cipher key as W0..W3 input (load cycle)
//   word_en     out  4  one-hot write enable for W0..W3 (all ones on load)
//   subrot_sel  out  1  route through RotWord/SubWord/Rcon (first word of a round)
//   rcon        out  8  Rcon for the round currently being computed
//   round_idx   out  4  index of the round key held in W0..W3
//   rk_valid    out  1  W0..W3 hold round key round_idx
//   done        out  1  one-cycle pulse after the last round key is taken
//
// Round-key handshake:
//   rk_valid is high exactly while in HOLD. A round key is transferred on a
//   rising edge where rk_valid and rk_ready are both high. While rk_valid is
//   high and rk_ready is low every output is held constant. rk_valid is never
//   high together with any word_en bit, so W0..W3 cannot change while offered.
//
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module key_expansion_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       rk_ready,
    output logic       busy,
    output logic       key_load,
    output logic [3:0] word_en,
    output logic       subrot_sel,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       rk_valid,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_EXPAND = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] j_q;
    logic [1:0] j_d;
    logic [3:0] round_q;
    logic [3:0] round_d;
    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            j_q     <= 2'd0;
            round_q <= 4'd0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        round_d = round_q;
        rcon_d  = rcon_q;

        case (state_q)
            ST_IDLE: begin
                // round_idx keeps the final value of the previous run while
                // idle; it and rcon are re-initialised only on the way into
                // LOAD so the load cycle already shows round 0.
                if (start) begin
                    state_d = ST_LOAD;
                    j_d     = 2'd0;
                    round_d = 4'd0;
                    rcon_d  = RCON_INIT;
                end
            end

            ST_LOAD: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (rk_ready) begin
                    j_d = 2'd0;
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXPAND;
                    end
                end
            end

            ST_EXPAND: begin
                j_d = j_q + 2'd1;
                // Fourth word written: the new round key is complete. Rcon
                // advances here so it is already correct for the next round.
                if (j_q == 2'd3) begin
                    state_d = ST_HOLD;
                    j_d     = 2'd0;
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                j_d     = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        key_load   = 1'b0;
        word_en    = 4'b0000;
        subrot_sel = 1'b0;
        rk_valid   = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end

            ST_LOAD: begin
                busy     = 1'b1;
                key_load = 1'b1;
                word_en  = 4'b1111;
            end

            ST_HOLD: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
            end

            ST_EXPAND: begin
                busy       = 1'b1;
                word_en    = 4'b0001 << j_q;
                subrot_sel = (j_q == 2'd0);
            end

            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end

            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rcon      = rcon_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_ctrl
//
// Directed bench for key_expansion_ctrl. Cycle c is the interval following
// rising edge c, where edge 0 is the edge that samples start. Outputs are
// checked on the falling edge of each cycle; inputs for the next edge are
// changed right after the check.
//
// Expected output words are packed as
//   {busy, key_load, word_en[3:0], subrot_sel, rcon[7:0], round_idx[3:0],
//    rk_valid, done}
// and are derived from the published timeline: LOAD at cycle 1, HOLD of
// round r at cycle 2+5r, four EXPAND cycles in between, DONE after round 10,
// with every stalled cycle in HOLD delaying the remainder by one.
// ---------------------------------------------------------------------------
module tb_key_expansion_ctrl;

  localparam int OUT_W = 21;

  logic       Clk;
  logic       Rst;
  logic       start;
  logic       rk_ready;
  logic       busy;
  logic       key_load;
  logic [3:0] word_en;
  logic       subrot_sel;
  logic [7:0] rcon;
  logic [3:0] round_idx;
  logic       rk_valid;
  logic       done;

  int n_tests;
  int n_fail;

  logic [OUT_W-1:0] exp_q[$];

  // Rcon shown while W0..W3 hold round key r (used for round r+1).
  // Entry 10 is xtime(8'h36) = 8'h6C, left behind after the final round.
  logic [7:0] rcon_tab [0:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36, 8'h6C};

  key_expansion_ctrl #(
    .NUM_ROUNDS (10),
    .RCON_INIT  (8'h01)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .rk_ready   (rk_ready),
    .busy       (busy),
    .key_load   (key_load),
    .word_en    (word_en),
    .subrot_sel (subrot_sel),
    .rcon       (rcon),
    .round_idx  (round_idx),
    .rk_valid   (rk_valid),
    .done       (done)
  );

  // ---------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] pack_out(
    input logic       b,
    input logic       kl,
    input logic [3:0] we,
    input logic       sr,
    input logic [7:0] rc,
    input logic [3:0] ri,
    input logic       v,
    input logic       d
  );
    return {b, kl, we, sr, rc, ri, v, d};
  endfunction

  function automatic logic [OUT_W-1:0] observed();
    return {busy, key_load, word_en, subrot_sel, rcon, round_idx, rk_valid, done};
  endfunction

  task automatic check_val(input string tag, input logic [OUT_W-1:0] obs,
                           input logic [OUT_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle c of a run started at edge 0, with an optional
  // stall of stall_n cycles while round key stall_r is offered.
  function automatic logic [OUT_W-1:0] exp_vec(input int c, input int stall_r,
                                               input int stall_n);
    int t;
    int r;
    int k;
    logic [3:0] one;
    one = 4'b0001;
    if (c == 1) return pack_out(1'b1, 1'b1, 4'b1111, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0);
    t = c - 2;
    if (stall_n > 0 && t >= 5 * stall_r) begin
      if (t < 5 * stall_r + stall_n) t = 5 * stall_r;
      else t = t - stall_n;
    end
    r = t / 5;
    k = t % 5;
    if (r < 10 || (r == 10 && k == 0)) begin
      if (k == 0)
        return pack_out(1'b1, 1'b0, 4'b0000, 1'b0, rcon_tab[r], 4'(r), 1'b1, 1'b0);
      else
        return pack_out(1'b1, 1'b0, one << (k - 1), (k == 1), rcon_tab[r], 4'(r),
                        1'b0, 1'b0);
    end
    if (r == 10 && k == 1)
      return pack_out(1'b1, 1'b0, 4'b0000, 1'b0, 8'h6C, 4'd10, 1'b0, 1'b1);
    return pack_out(1'b0, 1'b0, 4'b0000, 1'b0, 8'h6C, 4'd10, 1'b0, 1'b0);
  endfunction

  // Full expansion run. Called on a falling edge with the DUT idle.
  //   stall_r/stall_n : hold rk_ready low for stall_n cycles at round stall_r
  //   repulse         : assert start again during cycles 10 and 53
  //   abort_c         : if nonzero, assert Rst during cycle abort_c
  task automatic run_expansion(input string name, input int stall_r,
                               input int stall_n, input bit repulse,
                               input int abort_c);
    int last;
    logic [OUT_W-1:0] exp;
    last = 54 + stall_n;
    exp_q.delete();
    for (int c = 1; c <= last; c++) exp_q.push_back(exp_vec(c, stall_r, stall_n));

    rk_ready = 1'b1;
    start    = 1'b1;
    @(posedge Clk);  // edge 0
    for (int c = 1; c <= last; c++) begin
      @(negedge Clk);
      exp = exp_q.pop_front();
      check_val($sformatf("%s c%0d", name, c), observed(), exp);
      start    = repulse && (c == 10 || c == 53);
      rk_ready = !(stall_n > 0 && c >= 2 + 5 * stall_r &&
                   c < 2 + 5 * stall_r + stall_n);
      if (abort_c != 0 && c == abort_c) begin
        Rst = 1'b1;
        break;
      end
    end
    rk_ready = 1'b1;
    if (abort_c != 0) begin
      exp_q.delete();
      @(negedge Clk);
      check_val($sformatf("%s abort idle", name), observed(),
                pack_out(1'b0, 1'b0, 4'b0000, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0));
      Rst = 1'b0;
      @(negedge Clk);
      check_val($sformatf("%s abort stay", name), observed(),
                pack_out(1'b0, 1'b0, 4'b0000, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0));
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    Rst      = 1'b1;
    start    = 1'b1;
    rk_ready = 1'b1;

    // Reset held two edges with start high: start must not be taken.
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check_val("reset idle", observed(),
              pack_out(1'b0, 1'b0, 4'b0000, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0));
    Rst   = 1'b0;
    start = 1'b0;
    @(negedge Clk);
    check_val("post reset idle", observed(),
              pack_out(1'b0, 1'b0, 4'b0000, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0));

    run_expansion("plain", 0, 0, 1'b0, 0);
    run_expansion("stall", 4, 3, 1'b0, 0);
    run_expansion("repulse", 0, 0, 1'b1, 0);
    run_expansion("abort", 0, 0, 1'b0, 30);
    run_expansion("restart", 0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
